// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the MEM-stage stall sequencer: hold codes, FSM states
// and default bus widths.
package mem_stall_ctrl_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 64;

   localparam logic [1:0] HOLD_PASS  = 2'b00;
   localparam logic [1:0] HOLD_FLUSH = 2'b01;
   localparam logic [1:0] HOLD_KEEP  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } mem_state_e;

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Single-outstanding request/response data bus between the MEM-stage
// sequencer (master) and the memory side (slave).
interface mem_stall_ctrl_if
   import mem_stall_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/mem_stall_cnt.sv
// Saturating event counter; advances by one on each enabled cycle and
// sticks at all-ones.
module mem_stall_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer: runs one bus transaction per load/store, freezes the
// front of the pipeline while it is in flight and turns EX jumps into flushes.
//
// state  | meaning
// S_IDLE | no transaction; a load/store in EX/MEM is latched and starts one
// S_REQ  | request presented on the bus until accepted
// S_WAIT | waiting for the response, timeout timer running
// S_DONE | result/error pulse, pipeline released
module mem_stall_ctrl
   import mem_stall_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_ram_i,
   input  logic              write_ram_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              jump_flag_i,
   output logic              pc_hold_o,
   output logic [1:0]        if_id_hold_o,
   output logic [1:0]        id_ex_hold_o,
   output logic              ex_mem_en_o,
   mem_stall_ctrl_if.master  bus,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic              err_o,
   output logic [31:0]       stall_cnt_o
);

   localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT);

   mem_state_e        state_d, state_q;
   logic              we_d, we_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic [DATA_W-1:0] rdata_d, rdata_q;
   logic [7:0]        tmr_d, tmr_q;
   logic              rdata_vld_d, rdata_vld_q;
   logic              err_d, err_q;
   logic              stall;

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      tmr_d       = tmr_q;
      rdata_vld_d = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (read_ram_i || write_ram_i) begin
               we_d    = write_ram_i & ~read_ram_i;
               addr_d  = mem_addr_i;
               wdata_d = mem_wdata_i;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.req_ready) begin
               tmr_d   = TMR_LOAD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.rsp_valid) begin
               if (!we_q) begin
                  rdata_d = bus.rsp_rdata;
               end
               rdata_vld_d = ~we_q & ~bus.rsp_err;
               err_d       = bus.rsp_err;
               state_d     = S_DONE;
            end else if (tmr_q == 8'd0) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         tmr_q       <= '0;
         rdata_vld_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         tmr_q       <= tmr_d;
         rdata_vld_q <= rdata_vld_d;
         err_q       <= err_d;
      end
   end

   // Stall outranks flush: a jump held in ID/EX flushes once the stall drops.
   always_comb begin
      stall = ((state_q == S_IDLE) && (read_ram_i || write_ram_i)) ||
              (state_q == S_REQ) || (state_q == S_WAIT);
      pc_hold_o    = stall;
      ex_mem_en_o  = stall;
      if_id_hold_o = HOLD_PASS;
      id_ex_hold_o = HOLD_PASS;
      if (stall) begin
         if_id_hold_o = HOLD_KEEP;
         id_ex_hold_o = HOLD_KEEP;
      end else if (jump_flag_i) begin
         if_id_hold_o = HOLD_FLUSH;
         id_ex_hold_o = HOLD_FLUSH;
      end
   end

   assign bus.req_valid = (state_q == S_REQ);
   assign bus.req_we    = we_q;
   assign bus.req_addr  = addr_q;
   assign bus.req_wdata = wdata_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rdata_vld_q;
   assign err_o         = err_q;

   mem_stall_cnt #(.W(32)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (stall),
      .cnt_o (stall_cnt_o)
   );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Randomized bench for mem_stall_ctrl; expectations come from a
// transaction-level model of latency, stall accounting and result data.
module tb_mem_stall_ctrl;
   import mem_stall_ctrl_pkg::*;

   localparam int TIMEOUT_P = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        read_ram_i, write_ram_i, jump_flag_i;
   logic [31:0] mem_addr_i;
   logic [63:0] mem_wdata_i;
   logic        pc_hold_o, ex_mem_en_o, rdata_valid_o, err_o;
   logic [1:0]  if_id_hold_o, id_ex_hold_o;
   logic [63:0] rdata_o;
   logic [31:0] stall_cnt_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_rdata;
   int unsigned exp_stall;

   mem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(64)) bus_if ();

   mem_stall_ctrl #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TIMEOUT_P)) dut (
      .clk           (clk),
      .rst           (rst),
      .read_ram_i    (read_ram_i),
      .write_ram_i   (write_ram_i),
      .mem_addr_i    (mem_addr_i),
      .mem_wdata_i   (mem_wdata_i),
      .jump_flag_i   (jump_flag_i),
      .pc_hold_o     (pc_hold_o),
      .if_id_hold_o  (if_id_hold_o),
      .id_ex_hold_o  (id_ex_hold_o),
      .ex_mem_en_o   (ex_mem_en_o),
      .bus           (bus_if.master),
      .rdata_o       (rdata_o),
      .rdata_valid_o (rdata_valid_o),
      .err_o         (err_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_ctrl(input string tag, input logic stl, input logic jmp);
      logic [1:0] h;
      h = stl ? HOLD_KEEP : (jmp ? HOLD_FLUSH : HOLD_PASS);
      check_val({tag, "_pc_hold"}, 64'(pc_hold_o), 64'(stl));
      check_val({tag, "_ex_mem_en"}, 64'(ex_mem_en_o), 64'(stl));
      check_val({tag, "_if_id_hold"}, 64'(if_id_hold_o), 64'(h));
      check_val({tag, "_id_ex_hold"}, 64'(id_ex_hold_o), 64'(h));
   endtask

   task automatic check_reset_vals(input string tag);
      check_ctrl(tag, 1'b0, 1'b0);
      check_val({tag, "_req_valid"}, 64'(bus_if.req_valid), 64'd0);
      check_val({tag, "_req_we"}, 64'(bus_if.req_we), 64'd0);
      check_val({tag, "_req_addr"}, 64'(bus_if.req_addr), 64'd0);
      check_val({tag, "_req_wdata"}, bus_if.req_wdata, 64'd0);
      check_val({tag, "_rdata"}, rdata_o, 64'd0);
      check_val({tag, "_rdata_valid"}, 64'(rdata_valid_o), 64'd0);
      check_val({tag, "_err"}, 64'(err_o), 64'd0);
      check_val({tag, "_stall_cnt"}, 64'(stall_cnt_o), 64'd0);
   endtask

   task automatic idle_cycle(input logic jmp, input logic noise);
      @(posedge clk);
      #1;
      read_ram_i          = 1'b0;
      write_ram_i         = 1'b0;
      jump_flag_i         = jmp;
      bus_if.req_ready    = 1'($urandom);
      bus_if.rsp_valid    = noise;
      bus_if.rsp_err      = 1'($urandom);
      bus_if.rsp_rdata    = {$urandom, $urandom};
      @(negedge clk);
      check_ctrl("idle", 1'b0, jmp);
      check_val("idle_req_valid", 64'(bus_if.req_valid), 64'd0);
      check_val("idle_rdata_valid", 64'(rdata_valid_o), 64'd0);
      check_val("idle_err", 64'(err_o), 64'd0);
      check_val("idle_rdata", rdata_o, exp_rdata);
      check_val("idle_stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
   endtask

   // One complete load/store: detection, rdy_dly cycles of backpressure,
   // response after rsp_dly WAIT cycles (a timeout once rsp_dly > TIMEOUT).
   task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wdata, input int rdy_dly, input int rsp_dly,
                        input logic [63:0] rsp_data, input logic rerr, input logic jmp,
                        input logic noise);
      logic exp_we, timed_out;
      int   n_wait;
      exp_we    = wr & ~rd;
      timed_out = (rsp_dly > TIMEOUT_P);
      n_wait    = timed_out ? TIMEOUT_P + 1 : rsp_dly + 1;

      @(posedge clk);
      #1;
      read_ram_i       = rd;
      write_ram_i      = wr;
      mem_addr_i       = addr;
      mem_wdata_i      = wdata;
      jump_flag_i      = jmp;
      bus_if.req_ready = 1'b0;
      bus_if.rsp_valid = 1'b0;
      @(negedge clk);
      check_ctrl("detect", 1'b1, jmp);
      check_val("detect_req_valid", 64'(bus_if.req_valid), 64'd0);
      check_val("detect_rdata_valid", 64'(rdata_valid_o), 64'd0);
      check_val("detect_err", 64'(err_o), 64'd0);
      exp_stall++;

      for (int i = 0; i <= rdy_dly; i++) begin
         @(posedge clk);
         #1;
         mem_addr_i       = $urandom;
         mem_wdata_i      = {$urandom, $urandom};
         bus_if.req_ready = (i == rdy_dly);
         @(negedge clk);
         check_ctrl("req", 1'b1, jmp);
         check_val("req_valid", 64'(bus_if.req_valid), 64'd1);
         check_val("req_we", 64'(bus_if.req_we), 64'(exp_we));
         check_val("req_addr", 64'(bus_if.req_addr), 64'(addr));
         check_val("req_wdata", bus_if.req_wdata, wdata);
         exp_stall++;
      end

      for (int k = 0; k < n_wait; k++) begin
         logic hit;
         hit = !timed_out && (k == rsp_dly);
         @(posedge clk);
         #1;
         bus_if.req_ready = 1'b0;
         bus_if.rsp_valid = hit;
         bus_if.rsp_rdata = hit ? rsp_data : {$urandom, $urandom};
         bus_if.rsp_err   = hit ? rerr : 1'($urandom);
         @(negedge clk);
         check_ctrl("wait", 1'b1, jmp);
         check_val("wait_req_valid", 64'(bus_if.req_valid), 64'd0);
         check_val("wait_err", 64'(err_o), 64'd0);
         check_val("wait_rdata_valid", 64'(rdata_valid_o), 64'd0);
         exp_stall++;
      end

      @(posedge clk);
      #1;
      bus_if.rsp_valid = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
         read_ram_i  = 1'($urandom);
         write_ram_i = 1'($urandom);
      end
      @(negedge clk);
      if (!timed_out && !exp_we) exp_rdata = rsp_data;
      check_ctrl("done", 1'b0, jmp);
      check_val("done_req_valid", 64'(bus_if.req_valid), 64'd0);
      check_val("done_rdata_valid", 64'(rdata_valid_o), 64'(!timed_out && !exp_we && !rerr));
      check_val("done_err", 64'(err_o), 64'(timed_out || rerr));
      check_val("done_rdata", rdata_o, exp_rdata);
      check_val("done_stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
   endtask

   initial begin
      rst              = 1'b1;
      read_ram_i       = 1'b0;
      write_ram_i      = 1'b0;
      jump_flag_i      = 1'b0;
      mem_addr_i       = '0;
      mem_wdata_i      = '0;
      bus_if.req_ready = 1'b0;
      bus_if.rsp_valid = 1'b0;
      bus_if.rsp_rdata = '0;
      bus_if.rsp_err   = 1'b0;
      exp_rdata        = '0;
      exp_stall        = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");

      // Minimum-latency load
      do_op(1'b1, 1'b0, 32'h8000_0010, 64'h0, 0, 0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b0);
      check_val("min_load_stall_cnt", 64'(stall_cnt_o), 64'd3);
      check_val("min_load_rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
      idle_cycle(1'b0, 1'b0);

      // Store with four cycles of backpressure
      do_op(1'b0, 1'b1, 32'h1234_5678, 64'hA5A5_0000_FFFF_1111, 4, 1, 64'h0, 1'b0, 1'b0, 1'b0);
      // Jump with no memory op, then jump held across a load stall
      idle_cycle(1'b1, 1'b0);
      do_op(1'b1, 1'b0, 32'h0000_0040, 64'h0, 0, 2, 64'h0BAD_F00D_CAFE_0001, 1'b0, 1'b1, 1'b0);
      // Timeout: rdata_o must keep the previous load value
      do_op(1'b1, 1'b0, 32'h0000_0080, 64'h0, 1, TIMEOUT_P + 2, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0);
      check_val("timeout_rdata_kept", rdata_o, 64'h0BAD_F00D_CAFE_0001);
      idle_cycle(1'b0, 1'b1);
      // Read wins when both are set; errored load
      do_op(1'b1, 1'b1, 32'h0000_00C0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 1'b0);
      do_op(1'b1, 1'b0, 32'h0000_0100, 64'h0, 0, 1, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of WAIT, then a stale response
      @(posedge clk);
      #1;
      read_ram_i  = 1'b1;
      write_ram_i = 1'b0;
      mem_addr_i  = 32'hCAFE_0000;
      jump_flag_i = 1'b0;
      @(posedge clk);
      #1 bus_if.req_ready = 1'b1;
      @(posedge clk);
      #1 bus_if.req_ready = 1'b0;
      @(posedge clk);
      #1;
      rst         = 1'b1;
      read_ram_i  = 1'b0;
      @(posedge clk);
      #1;
      rst              = 1'b0;
      bus_if.rsp_valid = 1'b1;
      bus_if.rsp_err   = 1'b0;
      bus_if.rsp_rdata = 64'hFEED_FACE_FEED_FACE;
      @(negedge clk);
      check_reset_vals("mid_rst");
      exp_stall = 0;
      exp_rdata = '0;
      idle_cycle(1'b0, 1'b0);

      // Randomized traffic with random gaps (gap 0 is back-to-back)
      for (int n = 0; n < 60; n++) begin
         logic rd, wr;
         int   gap;
         rd = 1'($urandom);
         wr = rd ? 1'($urandom) : 1'b1;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) idle_cycle(1'($urandom), 1'($urandom));
         do_op(rd, wr, $urandom, {$urandom, $urandom},
               int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT_P + 2)),
               {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
               1'($urandom), 1'($urandom));
      end
      idle_cycle(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
